// File: rtl/cpu_bus_ctrl_if.sv
// CPU-side request/ack and tm/ad bus-side signals of cpu_bus_ctrl, bundled for port hookup.
// slave is the controller's view; master is the view of whatever drives the CPU and bus.
interface cpu_bus_ctrl_if;
  logic        cpu_req;
  logic [3:0]  cpu_write;
  logic        cpu_error;
  logic        cpu_ack;
  logic        cpu_err_o;
  logic [31:0] cpu_rdata;
  logic        cpu_busy;
  logic [3:0]  bus_write;
  logic        mst_adrcyn;
  logic        mst_dencyn;
  logic        bus_rdyn;
  logic [31:0] bus_ad_i;

  modport slave (
    input  cpu_req, cpu_write, cpu_error, bus_rdyn, bus_ad_i,
    output cpu_ack, cpu_err_o, cpu_rdata, cpu_busy, bus_write, mst_adrcyn, mst_dencyn
  );

  modport master (
    output cpu_req, cpu_write, cpu_error, bus_rdyn, bus_ad_i,
    input  cpu_ack, cpu_err_o, cpu_rdata, cpu_busy, bus_write, mst_adrcyn, mst_dencyn
  );
endinterface

// File: rtl/cpu_bus_ctrl.sv
// CPU-to-bus transfer controller: one address cycle, a data cycle stretched by bus_rdyn
// with a wait-state timeout, then a one-cycle cpu_ack. Every output is a registered copy.
module cpu_bus_ctrl #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic           clk,
  input  logic           rst_n,
  cpu_bus_ctrl_if.slave  bus
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ACK} state_t;

  state_t            state_q, state_n;
  logic [7:0]        cnt_q, cnt_n;
  logic [3:0]        bw_n;
  logic [DATA_W-1:0] rdata_n;
  logic              err_n;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    bw_n    = bus.bus_write;
    rdata_n = bus.cpu_rdata;
    err_n   = bus.cpu_err_o;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          if (bus.cpu_error) begin
            state_n = ACK;
            err_n   = 1'b1;
          end else begin
            state_n = ADDR;
            bw_n    = bus.cpu_write;
          end
        end
      end
      ADDR: begin
        state_n = DATA;
        cnt_n   = 8'd0;
      end
      DATA: begin
        // Ready is tested first so it wins over a timeout landing on the same cycle.
        if (!bus.bus_rdyn) begin
          state_n = ACK;
          err_n   = 1'b0;
          if (bus.bus_write == 4'b0000) rdata_n = bus.bus_ad_i;
        end else if (cnt_q == TIMEOUT) begin
          state_n = ACK;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      ACK: begin
        state_n = IDLE;
        err_n   = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      bus.bus_write  <= 4'b0000;
      bus.cpu_rdata  <= '0;
      bus.cpu_err_o  <= 1'b0;
      bus.cpu_ack    <= 1'b0;
      bus.cpu_busy   <= 1'b0;
      bus.mst_adrcyn <= 1'b1;
      bus.mst_dencyn <= 1'b1;
    end else begin
      state_q        <= state_n;
      cnt_q          <= cnt_n;
      bus.bus_write  <= bw_n;
      bus.cpu_rdata  <= rdata_n;
      bus.cpu_err_o  <= err_n;
      bus.cpu_ack    <= (state_n == ACK);
      bus.cpu_busy   <= (state_n != IDLE);
      bus.mst_adrcyn <= (state_n != ADDR);
      bus.mst_dencyn <= (state_n != DATA);
    end
  end

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Directed bench for cpu_bus_ctrl (TIMEOUT=4): read, write with waits, illegal strobe,
// timeout and ready-at-timeout, back-to-back spacing, and reset during a transfer.
module tb_cpu_bus_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  cpu_bus_ctrl_if bif();

  cpu_bus_ctrl #(.TIMEOUT(8'd4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_adrcyn"}, 32'(bif.mst_adrcyn), 32'd1);
    chk({tag, "_dencyn"}, 32'(bif.mst_dencyn), 32'd1);
    chk({tag, "_ack"},    32'(bif.cpu_ack),    32'd0);
    chk({tag, "_err"},    32'(bif.cpu_err_o),  32'd0);
    chk({tag, "_busy"},   32'(bif.cpu_busy),   32'd0);
    chk({tag, "_bw"},     32'(bif.bus_write),  32'd0);
    chk({tag, "_rdata"},  bif.cpu_rdata,       32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bif.cpu_req   = 1'b0;
    bif.cpu_write = 4'b0000;
    bif.cpu_error = 1'b0;
    bif.bus_rdyn  = 1'b1;
    bif.bus_ad_i  = 32'h0;
    tick();
    tick();
    chk_reset_vals("rst0");
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(bif.cpu_busy), 32'd0);

    // Read, ready on first data cycle
    bif.cpu_req = 1'b1;
    tick();
    chk("rd_addr_adrcyn", 32'(bif.mst_adrcyn), 32'd0);
    chk("rd_addr_dencyn", 32'(bif.mst_dencyn), 32'd1);
    chk("rd_addr_busy",   32'(bif.cpu_busy),   32'd1);
    bif.cpu_req  = 1'b0;
    bif.bus_rdyn = 1'b0;
    bif.bus_ad_i = 32'hDEADBEEF;
    tick();
    chk("rd_data_adrcyn", 32'(bif.mst_adrcyn), 32'd1);
    chk("rd_data_dencyn", 32'(bif.mst_dencyn), 32'd0);
    chk("rd_data_ack",    32'(bif.cpu_ack),    32'd0);
    tick();
    chk("rd_ack",        32'(bif.cpu_ack),    32'd1);
    chk("rd_ack_err",    32'(bif.cpu_err_o),  32'd0);
    chk("rd_ack_rdata",  bif.cpu_rdata,       32'hDEADBEEF);
    chk("rd_ack_dencyn", 32'(bif.mst_dencyn), 32'd1);
    chk("rd_ack_busy",   32'(bif.cpu_busy),   32'd1);
    bif.bus_rdyn = 1'b1;
    bif.bus_ad_i = 32'h12345678;
    tick();
    chk("rd_idle_ack",   32'(bif.cpu_ack),  32'd0);
    chk("rd_idle_busy",  32'(bif.cpu_busy), 32'd0);
    chk("rd_hold_rdata", bif.cpu_rdata,     32'hDEADBEEF);

    // Write with three wait states; cpu_write changes after accept
    bif.cpu_req   = 1'b1;
    bif.cpu_write = 4'b1100;
    tick();
    chk("wr_addr_adrcyn", 32'(bif.mst_adrcyn), 32'd0);
    bif.cpu_req   = 1'b0;
    bif.cpu_write = 4'b0011;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wr_wait%0d_dencyn", i), 32'(bif.mst_dencyn), 32'd0);
      chk($sformatf("wr_wait%0d_ack", i),    32'(bif.cpu_ack),    32'd0);
      chk($sformatf("wr_wait%0d_bw", i),     32'(bif.bus_write),  32'hC);
      tick();
    end
    chk("wr_d4_dencyn", 32'(bif.mst_dencyn), 32'd0);
    chk("wr_d4_ack",    32'(bif.cpu_ack),    32'd0);
    bif.bus_rdyn = 1'b0;
    tick();
    chk("wr_ack",       32'(bif.cpu_ack),   32'd1);
    chk("wr_ack_err",   32'(bif.cpu_err_o), 32'd0);
    chk("wr_ack_bw",    32'(bif.bus_write), 32'hC);
    chk("wr_ack_rdata", bif.cpu_rdata,      32'hDEADBEEF);
    bif.bus_rdyn = 1'b1;
    tick();
    chk("wr_idle_ack", 32'(bif.cpu_ack), 32'd0);

    // Illegal strobe: straight to ack with error, no bus cycle
    bif.cpu_req   = 1'b1;
    bif.cpu_write = 4'b0101;
    bif.cpu_error = 1'b1;
    tick();
    chk("ill_ack",    32'(bif.cpu_ack),    32'd1);
    chk("ill_err",    32'(bif.cpu_err_o),  32'd1);
    chk("ill_adrcyn", 32'(bif.mst_adrcyn), 32'd1);
    chk("ill_dencyn", 32'(bif.mst_dencyn), 32'd1);
    bif.cpu_req   = 1'b0;
    bif.cpu_error = 1'b0;
    tick();
    chk("ill_idle_ack",    32'(bif.cpu_ack),    32'd0);
    chk("ill_idle_adrcyn", 32'(bif.mst_adrcyn), 32'd1);

    // Timeout: ready stuck high, five data cycles then error ack
    bif.cpu_req   = 1'b1;
    bif.cpu_write = 4'b0000;
    bif.bus_ad_i  = 32'hCAFEF00D;
    tick();
    bif.cpu_req = 1'b0;
    tick();
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("to_d%0d_dencyn", i), 32'(bif.mst_dencyn), 32'd0);
      chk($sformatf("to_d%0d_ack", i),    32'(bif.cpu_ack),    32'd0);
      tick();
    end
    chk("to_ack",       32'(bif.cpu_ack),    32'd1);
    chk("to_ack_err",   32'(bif.cpu_err_o),  32'd1);
    chk("to_ack_rdata", bif.cpu_rdata,       32'hDEADBEEF);
    chk("to_ack_dencyn",32'(bif.mst_dencyn), 32'd1);
    tick();

    // Ready arriving on the fifth data cycle wins over the timeout
    bif.cpu_req = 1'b1;
    tick();
    bif.cpu_req = 1'b0;
    tick();
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("tr_d%0d_dencyn", i), 32'(bif.mst_dencyn), 32'd0);
      tick();
    end
    chk("tr_d5_dencyn", 32'(bif.mst_dencyn), 32'd0);
    chk("tr_d5_ack",    32'(bif.cpu_ack),    32'd0);
    bif.bus_rdyn = 1'b0;
    tick();
    chk("tr_ack",       32'(bif.cpu_ack),   32'd1);
    chk("tr_ack_err",   32'(bif.cpu_err_o), 32'd0);
    chk("tr_ack_rdata", bif.cpu_rdata,      32'hCAFEF00D);
    tick();

    // Back-to-back: request held high, ready immediate -> period of 4
    bif.cpu_req   = 1'b1;
    bif.cpu_write = 4'b0001;
    tick();
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("b2b_%0d_adrcyn", i), 32'(bif.mst_adrcyn), 32'((i % 4) != 0));
      chk($sformatf("b2b_%0d_ack", i),    32'(bif.cpu_ack),    32'((i % 4) == 2));
      chk($sformatf("b2b_%0d_busy", i),   32'(bif.cpu_busy),   32'((i % 4) != 3));
      tick();
    end
    chk("b2b_12_adrcyn", 32'(bif.mst_adrcyn), 32'd0);
    chk("b2b_bw",        32'(bif.bus_write),  32'h1);

    // Reset during DATA: abort, no ack, then a normal read
    bif.cpu_req   = 1'b0;
    bif.cpu_write = 4'b0000;
    bif.bus_rdyn  = 1'b1;
    tick();
    chk("mid_data_dencyn", 32'(bif.mst_dencyn), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    tick();
    chk_reset_vals("rst_hold");
    rst_n = 1'b1;
    tick();
    chk("post_rst_ack",  32'(bif.cpu_ack),  32'd0);
    chk("post_rst_busy", 32'(bif.cpu_busy), 32'd0);
    bif.cpu_req  = 1'b1;
    bif.bus_rdyn = 1'b0;
    bif.bus_ad_i = 32'h0BADCAFE;
    tick();
    chk("post_addr_adrcyn", 32'(bif.mst_adrcyn), 32'd0);
    bif.cpu_req = 1'b0;
    tick();
    chk("post_data_dencyn", 32'(bif.mst_dencyn), 32'd0);
    tick();
    chk("post_ack",       32'(bif.cpu_ack),   32'd1);
    chk("post_ack_err",   32'(bif.cpu_err_o), 32'd0);
    chk("post_ack_rdata", bif.cpu_rdata,      32'h0BADCAFE);
    tick();
    chk("post_idle_ack", 32'(bif.cpu_ack), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
